control_unit: RTL

//  Instruction sequencer for the 8-bit micro. Fetches 16-bit words {opcode,operand} from program

---
 rtl/control_unit_pkg.sv | 78 +++++++
 rtl/control_unit_opcode_decoder.sv | 52 +++++
 rtl/control_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared opcodes, flag indices, FSM states and decode bundle for the
// 8-bit micro's instruction sequencer.
package control_unit_pkg;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OV    = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;

    // Bit 0 of an ALU/LOAD opcode selects the memory operand form.
    localparam int   ALU_OPER2_BIT = 0;
    localparam logic ALU_OPER2_X   = 1'b1;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_LOAD_I  = 8'h10;
    localparam logic [7:0] OP_LOAD_X  = 8'h11;
    localparam logic [7:0] OP_ADD_I   = 8'h20;
    localparam logic [7:0] OP_ADD_X   = 8'h21;
    localparam logic [7:0] OP_SUB_I   = 8'h22;
    localparam logic [7:0] OP_SUB_X   = 8'h23;
    localparam logic [7:0] OP_AND_I   = 8'h24;
    localparam logic [7:0] OP_AND_X   = 8'h25;
    localparam logic [7:0] OP_OR_I    = 8'h26;
    localparam logic [7:0] OP_OR_X    = 8'h27;
    localparam logic [7:0] OP_XOR_I   = 8'h28;
    localparam logic [7:0] OP_XOR_X   = 8'h29;
    localparam logic [7:0] OP_STORE_I = 8'h40;
    localparam logic [7:0] OP_STORE_X = 8'h41;
    localparam logic [7:0] OP_JMP     = 8'h50;
    localparam logic [7:0] OP_JZ      = 8'h51;
    localparam logic [7:0] OP_JNZ     = 8'h52;
    localparam logic [7:0] OP_JC      = 8'h53;
    localparam logic [7:0] OP_JN      = 8'h54;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_MEMLAT = 3'd3,
        S_EXEC   = 3'd4,
        S_STORE  = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        J_ALWAYS = 3'd0,
        J_Z      = 3'd1,
        J_NZ     = 3'd2,
        J_C      = 3'd3,
        J_N      = 3'd4
    } jcond_t;

    typedef struct packed {
        logic   is_alu;
        logic   is_mem_oper;
        logic   is_store;
        logic   is_jump;
        jcond_t jcond;
        logic   is_halt;
    } dec_t;

    function automatic logic jump_taken(jcond_t c, logic [3:0] f);
        logic t;
        t = 1'b0;
        unique case (c)
            J_ALWAYS: t = 1'b1;
            J_Z:      t = f[FLAG_ZERO];
            J_NZ:     t = !f[FLAG_ZERO];
            J_C:      t = f[FLAG_CARRY];
            J_N:      t = f[FLAG_NEG];
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// Combinational opcode classifier used by the sequencer's DECODE step.
// LOAD is grouped with the ALU ops since it travels the same operand path.
module opcode_decoder
    import control_unit_pkg::*;
(
    input  logic [7:0] op_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (op_i)
            OP_LOAD_I, OP_LOAD_X,
            OP_ADD_I,  OP_ADD_X,
            OP_SUB_I,  OP_SUB_X,
            OP_AND_I,  OP_AND_X,
            OP_OR_I,   OP_OR_X,
            OP_XOR_I,  OP_XOR_X: begin
                dec_o.is_alu      = 1'b1;
                dec_o.is_mem_oper = (op_i[ALU_OPER2_BIT] == ALU_OPER2_X);
            end
            OP_STORE_X: begin
                dec_o.is_store    = 1'b1;
                dec_o.is_mem_oper = 1'b1;
            end
            OP_STORE_I: dec_o.is_store = 1'b1;
            OP_JMP: begin
                dec_o.is_jump = 1'b1;
                dec_o.jcond   = J_ALWAYS;
            end
            OP_JZ: begin
                dec_o.is_jump = 1'b1;
                dec_o.jcond   = J_Z;
            end
            OP_JNZ: begin
                dec_o.is_jump = 1'b1;
                dec_o.jcond   = J_NZ;
            end
            OP_JC: begin
                dec_o.is_jump = 1'b1;
                dec_o.jcond   = J_C;
            end
            OP_JN: begin
                dec_o.is_jump = 1'b1;
                dec_o.jcond   = J_N;
            end
            OP_HALT: dec_o.is_halt = 1'b1;
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: owns PC, fetches {opcode,operand}, feeds the ALU,
// handles memory operands, stores, conditional jumps and HALT.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_ADDRESS = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       run,
    output logic [N_ADDRESS-1:0]       pm_addr,
    input  logic [N_ADDRESS+WIDTH-1:0] pm_data,
    output logic [N_ADDRESS-1:0]       dm_addr,
    input  logic [WIDTH-1:0]           dm_rdata,
    output logic [WIDTH-1:0]           dm_wdata,
    output logic                       dm_we,
    input  logic [WIDTH-1:0]           AR,
    input  logic [3:0]                 Flags,
    output logic [N_ADDRESS-1:0]       IR,
    output logic [WIDTH-1:0]           IBR,
    output logic [WIDTH-1:0]           MBR,
    output logic                       Exec,
    output logic                       halted
);

    state_t                 state_q, state_d;
    logic [N_ADDRESS-1:0]   pc_q, pc_d;
    logic [N_ADDRESS-1:0]   ir_q, ir_d;
    logic [WIDTH-1:0]       ibr_q, ibr_d;
    logic [WIDTH-1:0]       mbr_q, mbr_d;
    logic [N_ADDRESS-1:0]   dma_q, dma_d;
    jcond_t                 jcond_q, jcond_d;
    logic                   exec_q, exec_d;
    logic                   we_q, we_d;
    logic                   halted_q, halted_d;

    logic [N_ADDRESS-1:0]   op_w;
    logic [WIDTH-1:0]       opnd_w;
    dec_t                   dec;
    logic                   flags_unused;

    assign op_w   = pm_data[N_ADDRESS+WIDTH-1 -: N_ADDRESS];
    assign opnd_w = pm_data[WIDTH-1:0];
    assign flags_unused = Flags[FLAG_OV];

    opcode_decoder u_dec (
        .op_i  (8'(op_w)),
        .dec_o (dec)
    );

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= N_ADDRESS'(OP_NOP);
            ibr_q    <= '0;
            mbr_q    <= '0;
            dma_q    <= '0;
            jcond_q  <= J_ALWAYS;
            exec_q   <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ibr_q    <= ibr_d;
            mbr_q    <= mbr_d;
            dma_q    <= dma_d;
            jcond_q  <= jcond_d;
            exec_q   <= exec_d;
            we_q     <= we_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    dec.is_halt:  state_d = S_HALT;
                    dec.is_jump:  state_d = S_JUMP;
                    dec.is_store: state_d = S_STORE;
                    dec.is_alu:   state_d = dec.is_mem_oper ? S_MEMRD
                                                            : S_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMRD:  state_d = S_MEMLAT;
            S_MEMLAT: state_d = S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Strobes are registered from the next state so they are high
    // exactly during the EXEC / STORE / HALT cycles.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ibr_d    = ibr_q;
        mbr_d    = mbr_q;
        dma_d    = dma_q;
        jcond_d  = jcond_q;
        exec_d   = (state_d == S_EXEC);
        we_d     = (state_d == S_STORE);
        halted_d = (state_d == S_HALT);
        unique case (state_q)
            S_DECODE: begin
                ir_d    = op_w;
                ibr_d   = opnd_w;
                pc_d    = pc_q + N_ADDRESS'(1);
                jcond_d = dec.jcond;
                if (dec.is_store && !dec.is_mem_oper) begin
                    dma_d = N_ADDRESS'(mbr_q);
                end else if (dec.is_mem_oper) begin
                    dma_d = N_ADDRESS'(opnd_w);
                end
            end
            S_MEMLAT: mbr_d = dm_rdata;
            S_JUMP: begin
                if (jump_taken(jcond_q, Flags)) begin
                    pc_d = N_ADDRESS'(ibr_q);
                end
            end
            default: ;
        endcase
    end

    assign pm_addr  = pc_q;
    assign dm_wdata = AR;
    assign dm_addr  = dma_q;
    assign dm_we    = we_q;
    assign IR       = ir_q;
    assign IBR      = ibr_q;
    assign MBR      = mbr_q;
    assign Exec     = exec_q;
    assign halted   = halted_q;

endmodule
